// File: rtl/id_inst_queue_if.sv
// IF->queue->ID bundle for id_inst_queue: fetch group in, decode window out.
// fetch_valid is qualified by fetch_ready. A fetch group is taken only if fetch_ready is 1 at the edge; otherwise the group is dropped and IF must re-offer it. dec_valid/dec_accept are thermometer codes: slot i is consumed only if slots 0..i are all valid and accepted.
interface id_inst_queue_if #(
  parameter int FETCH_WIDTH  = 2,
  parameter int DECODE_WIDTH = 2,
  parameter int GHR_WIDTH    = 10
);
  logic [FETCH_WIDTH-1:0]            fetch_valid;
  logic                              fetch_ready;
  logic [32*FETCH_WIDTH-1:0]         fetch_pc;
  logic [32*FETCH_WIDTH-1:0]         fetch_inst;
  logic [FETCH_WIDTH-1:0]            fetch_taken;
  logic [GHR_WIDTH*FETCH_WIDTH-1:0]  fetch_pht_index;

  logic [DECODE_WIDTH-1:0]           dec_valid;
  logic [DECODE_WIDTH-1:0]           dec_accept;
  logic [DECODE_WIDTH-1:0]           dec_is_branch;
  logic [32*DECODE_WIDTH-1:0]        dec_pc;
  logic [32*DECODE_WIDTH-1:0]        dec_inst;
  logic [DECODE_WIDTH-1:0]           dec_taken;
  logic [GHR_WIDTH*DECODE_WIDTH-1:0] dec_pht_index;
  logic [DECODE_WIDTH-1:0]           dec_is_delayslot;

  // master: the IF/ID pipeline around the queue; slave: the queue itself
  modport master (
    output fetch_valid, fetch_pc, fetch_inst, fetch_taken, fetch_pht_index,
    output dec_accept, dec_is_branch,
    input  fetch_ready, dec_valid, dec_pc, dec_inst, dec_taken, dec_pht_index,
    input  dec_is_delayslot
  );

  modport slave (
    input  fetch_valid, fetch_pc, fetch_inst, fetch_taken, fetch_pht_index,
    input  dec_accept, dec_is_branch,
    output fetch_ready, dec_valid, dec_pc, dec_inst, dec_taken, dec_pht_index,
    output dec_is_delayslot
  );
endinterface

// File: rtl/id_inst_queue.sv
// Multi-wide instruction queue between IF and ID with branch delay-slot tracking.
// Optional same-cycle bypass of an empty queue: define ID_QUEUE_BYPASS_EN.
module id_inst_queue #(
  parameter int DEPTH        = 8,
  parameter int FETCH_WIDTH  = 2,
  parameter int DECODE_WIDTH = 2,
  parameter int GHR_WIDTH    = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  id_inst_queue_if.slave         bus,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]        head, tail;
  logic                 ds_flag;
  logic [31:0]          mem_pc   [DEPTH];
  logic [31:0]          mem_inst [DEPTH];
  logic                 mem_taken[DEPTH];
  logic [GHR_WIDTH-1:0] mem_pht  [DEPTH];

  logic [CW-1:0] p, push_n, k, skip;
  logic          byp, br_last, run_f, run_d;

  assign bus.fetch_ready = (CW'(DEPTH) - count) >= CW'(FETCH_WIDTH);

  always_comb begin
    p     = '0;
    run_f = 1'b1;
    for (int j = 0; j < FETCH_WIDTH; j++) begin
      if (run_f && bus.fetch_valid[j]) p = p + CW'(1);
      else                             run_f = 1'b0;
    end
  end

  assign push_n = (bus.fetch_ready && !flush) ? p : '0;

`ifdef ID_QUEUE_BYPASS_EN
  assign byp = rst && !flush && (count == '0);
`else
  assign byp = 1'b0;
`endif

  for (genvar i = 0; i < DECODE_WIDTH; i++) begin : g_slot
    logic [AW-1:0]        idx;
    logic                 reg_v, byp_v;
    logic [31:0]          f_pc, f_inst;
    logic                 f_taken;
    logic [GHR_WIDTH-1:0] f_pht;

    assign idx   = head + AW'(i);
    assign reg_v = CW'(i) < count;

    if (i < FETCH_WIDTH) begin : g_fetch
      assign byp_v   = byp && (CW'(i) < p);
      assign f_pc    = bus.fetch_pc[32*i +: 32];
      assign f_inst  = bus.fetch_inst[32*i +: 32];
      assign f_taken = bus.fetch_taken[i];
      assign f_pht   = bus.fetch_pht_index[GHR_WIDTH*i +: GHR_WIDTH];
    end else begin : g_nofetch
      assign byp_v   = 1'b0;
      assign f_pc    = '0;
      assign f_inst  = '0;
      assign f_taken = 1'b0;
      assign f_pht   = '0;
    end

    assign bus.dec_valid[i]    = reg_v | byp_v;
    assign bus.dec_pc[32*i +: 32]   = byp_v ? f_pc   : (reg_v ? mem_pc[idx]   : '0);
    assign bus.dec_inst[32*i +: 32] = byp_v ? f_inst : (reg_v ? mem_inst[idx] : '0);
    assign bus.dec_taken[i]    = byp_v ? f_taken : (reg_v & mem_taken[idx]);
    assign bus.dec_pht_index[GHR_WIDTH*i +: GHR_WIDTH] =
      byp_v ? f_pht : (reg_v ? mem_pht[idx] : '0);

    // Slot 0 inherits the branch status of the last slot popped in an earlier cycle
    if (i == 0) begin : g_ds0
      assign bus.dec_is_delayslot[0] = ds_flag & bus.dec_valid[0];
    end else begin : g_dsn
      assign bus.dec_is_delayslot[i] = bus.dec_is_branch[i-1] & bus.dec_valid[i];
    end
  end

  always_comb begin
    k       = '0;
    br_last = 1'b0;
    run_d   = 1'b1;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      if (run_d && bus.dec_accept[i] && bus.dec_valid[i]) begin
        k       = k + CW'(1);
        br_last = bus.dec_is_branch[i];
      end else begin
        run_d = 1'b0;
      end
    end
  end

  // Bypassed slots the decoder took never enter storage
  assign skip = byp ? k : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      ds_flag <= 1'b0;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      ds_flag <= 1'b0;
    end else begin
      head  <= head + (byp ? '0 : AW'(k));
      tail  <= tail + AW'(push_n - skip);
      count <= count + push_n - k;
      if (k != '0) ds_flag <= br_last;
    end
  end

  always_ff @(posedge clk) begin
    if (push_n != '0) begin
      for (int j = 0; j < FETCH_WIDTH; j++) begin
        if (CW'(j) >= skip && CW'(j) < push_n) begin
          mem_pc   [tail + AW'(CW'(j) - skip)] <= bus.fetch_pc[32*j +: 32];
          mem_inst [tail + AW'(CW'(j) - skip)] <= bus.fetch_inst[32*j +: 32];
          mem_taken[tail + AW'(CW'(j) - skip)] <= bus.fetch_taken[j];
          mem_pht  [tail + AW'(CW'(j) - skip)] <= bus.fetch_pht_index[GHR_WIDTH*j +: GHR_WIDTH];
        end
      end
    end
  end
endmodule

// File: tb/tb_id_inst_queue.sv
// Directed + random bench for id_inst_queue (DEPTH 8, 2-in/2-out) with a queue-based reference.
module tb_id_inst_queue;
`ifdef ID_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       flush;
  logic [3:0] count;

  id_inst_queue_if #(.FETCH_WIDTH(2), .DECODE_WIDTH(2), .GHR_WIDTH(10)) bus ();

  id_inst_queue #(.DEPTH(8), .FETCH_WIDTH(2), .DECODE_WIDTH(2), .GHR_WIDTH(10)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus),
    .count (count)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  logic [74:0] exp_q[$];
  logic        m_ds;
  int          n_cmp;
  int          n_fail;

  // Entry layout: {pc[74:43], inst[42:11], taken[10], pht[9:0]}
  function automatic logic [74:0] mk(input logic [31:0] pc);
    return {pc, pc ^ 32'h1234_0013, pc[2], pc[11:2]};
  endfunction

  function automatic logic [74:0] slot_obs(input int i);
    return {bus.dec_pc[32*i +: 32], bus.dec_inst[32*i +: 32],
            bus.dec_taken[i], bus.dec_pht_index[10*i +: 10]};
  endfunction

  task automatic check(input string tag, input logic [74:0] obs, input logic [74:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [1:0] fv, input logic [31:0] pc0, input logic [1:0] acc,
                       input logic [1:0] br, input logic fl);
    logic [74:0] e0, e1;
    e0 = mk(pc0);
    e1 = mk(pc0 + 32'd4);
    bus.fetch_valid     = fv;
    bus.fetch_pc        = {e1[74:43], e0[74:43]};
    bus.fetch_inst      = {e1[42:11], e0[42:11]};
    bus.fetch_taken     = {e1[10], e0[10]};
    bus.fetch_pht_index = {e1[9:0], e0[9:0]};
    bus.dec_accept      = acc;
    bus.dec_is_branch   = br;
    flush               = fl;
    #1;
  endtask

  // Compare the presented window against the reference, then apply one clock edge to both
  task automatic tick();
    logic [74:0] inc[$];
    logic [74:0] pres[$];
    logic [74:0] e;
    logic [1:0]  ev, eds, av;
    logic        ready_m, byp_m;
    int          p_m, k_m;
    p_m = bus.fetch_valid[0] ? (bus.fetch_valid[1] ? 2 : 1) : 0;
    for (int j = 0; j < p_m; j++) inc.push_back(mk(bus.fetch_pc[32*j +: 32]));
    ready_m = (8 - exp_q.size()) >= 2;
    byp_m   = BYP && (exp_q.size() == 0) && !flush;
    if (byp_m) begin
      for (int i = 0; i < p_m && i < 2; i++) pres.push_back(inc[i]);
    end else begin
      for (int i = 0; i < exp_q.size() && i < 2; i++) pres.push_back(exp_q[i]);
    end
    ev = (pres.size() == 0) ? 2'b00 : (pres.size() == 1) ? 2'b01 : 2'b11;
    check("count", 75'(count), 75'(exp_q.size()));
    check("fetch_ready", 75'(bus.fetch_ready), 75'(ready_m));
    check("dec_valid", 75'(bus.dec_valid), 75'(ev));
    for (int i = 0; i < 2; i++) begin
      e = (i < pres.size()) ? pres[i] : '0;
      check($sformatf("slot%0d", i), slot_obs(i), e);
    end
    eds = {bus.dec_is_branch[0] & ev[1], m_ds & ev[0]};
    check("delayslot", 75'(bus.dec_is_delayslot), 75'(eds));
    av  = bus.dec_accept & ev;
    k_m = av[0] ? (av[1] ? 2 : 1) : 0;
    if (flush) begin
      exp_q.delete();
      m_ds = 1'b0;
    end else begin
      if (k_m > 0) m_ds = bus.dec_is_branch[k_m-1];
      if (byp_m) begin
        for (int j = k_m; j < p_m; j++) exp_q.push_back(inc[j]);
      end else begin
        repeat (k_m) void'(exp_q.pop_front());
        if (ready_m) for (int j = 0; j < p_m; j++) exp_q.push_back(inc[j]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] pc;
    n_cmp  = 0;
    n_fail = 0;
    m_ds   = 1'b0;
    rst    = 1'b1;
    drive(2'b00, 32'h0, 2'b00, 2'b00, 1'b0);
    #1 rst = 1'b0;
    #1;
    check("reset_count", 75'(count), 75'(0));
    check("reset_valid", 75'(bus.dec_valid), 75'(0));
    check("reset_ready", 75'(bus.fetch_ready), 75'(1));
    check("reset_ds", 75'(bus.dec_is_delayslot), 75'(0));
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    // Fill to full, then offer a fifth pair that must be dropped
    for (int n = 0; n < 4; n++) begin
      drive(2'b11, 32'h1000 + 32'(8*n), 2'b00, 2'b00, 1'b0);
      tick();
    end
    drive(2'b11, 32'h2000, 2'b00, 2'b00, 1'b0);
    check("full_count", 75'(count), 75'(8));
    check("full_ready", 75'(bus.fetch_ready), 75'(0));
    check("full_pc0", 75'(bus.dec_pc[31:0]), 75'(32'h1000));
    check("full_pc1", 75'(bus.dec_pc[63:32]), 75'(32'h1004));
    tick();
    drive(2'b00, 32'h0, 2'b00, 2'b00, 1'b0);
    check("full_hold", 75'(count), 75'(8));

    // Drain to head=6, refill to count 7, then pop across the wrap
    repeat (3) begin
      drive(2'b00, 32'h0, 2'b11, 2'b00, 1'b0);
      tick();
    end
    drive(2'b11, 32'h3000, 2'b00, 2'b00, 1'b0); tick();
    drive(2'b11, 32'h3008, 2'b00, 2'b00, 1'b0); tick();
    drive(2'b01, 32'h3010, 2'b00, 2'b00, 1'b0); tick();
    check("wrap_head6", 75'(dut.head), 75'(6));
    check("wrap_tail5", 75'(dut.tail), 75'(5));
    drive(2'b01, 32'h3020, 2'b11, 2'b00, 1'b0);
    check("wrap_noready", 75'(bus.fetch_ready), 75'(0));
    tick();
    check("wrap_head0", 75'(dut.head), 75'(0));
    check("wrap_count", 75'(count), 75'(5));
    drive(2'b10, 32'h3030, 2'b00, 2'b00, 1'b0); tick();
    drive(2'b01, 32'h3040, 2'b11, 2'b00, 1'b0); tick();
    check("wrap_tail6", 75'(dut.tail), 75'(6));
    check("wrap_head2", 75'(dut.head), 75'(2));
    drive(2'b01, 32'h3050, 2'b10, 2'b00, 1'b0); tick();

    // Asynchronous reset mid-operation
    check("pre_rst_count", 75'(count), 75'(5));
    rst = 1'b0;
    drive(2'b00, 32'h0, 2'b00, 2'b00, 1'b0);
    check("rst_async_count", 75'(count), 75'(0));
    check("rst_async_valid", 75'(bus.dec_valid), 75'(0));
    check("rst_async_ready", 75'(bus.fetch_ready), 75'(1));
    exp_q.delete();
    m_ds = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    // Delay slot inside a group and carried across cycles
    drive(2'b11, 32'h100, 2'b00, 2'b00, 1'b0); tick();
    drive(2'b00, 32'h0, 2'b01, 2'b01, 1'b0);
    check("ds_in_group", 75'(bus.dec_is_delayslot), 75'(2'b10));
    tick();
    drive(2'b00, 32'h0, 2'b00, 2'b00, 1'b0);
    check("ds_carry_pc", 75'(bus.dec_pc[31:0]), 75'(32'h104));
    check("ds_carry", 75'(bus.dec_is_delayslot), 75'(2'b01));
    tick();
    drive(2'b00, 32'h0, 2'b01, 2'b00, 1'b0); tick();

    // Flush with count=4 and ds_flag set
    drive(2'b11, 32'h400, 2'b00, 2'b00, 1'b0); tick();
    drive(2'b11, 32'h408, 2'b11, 2'b10, 1'b0); tick();
    drive(2'b11, 32'h410, 2'b00, 2'b00, 1'b0); tick();
    check("pre_flush_count", 75'(count), 75'(4));
    check("pre_flush_ds", 75'(dut.ds_flag), 75'(1));
    drive(2'b11, 32'h500, 2'b11, 2'b11, 1'b1); tick();
    check("flush_count", 75'(count), 75'(0));
    check("flush_ds", 75'(dut.ds_flag), 75'(0));
    check("flush_ready", 75'(bus.fetch_ready), 75'(1));
    drive(2'b11, 32'h600, 2'b00, 2'b00, 1'b0); tick();
    drive(2'b00, 32'h0, 2'b00, 2'b00, 1'b0);
    check("post_flush_pc", 75'(bus.dec_pc[31:0]), 75'(32'h600));
    tick();

    // Empty-queue presentation: bypass shows the group at once, otherwise one cycle later
    drive(2'b00, 32'h0, 2'b11, 2'b00, 1'b0); tick();
    drive(2'b11, 32'h200, 2'b01, 2'b00, 1'b0);
    check("empty_valid", 75'(bus.dec_valid), 75'(BYP ? 2'b11 : 2'b00));
    tick();
    drive(2'b00, 32'h0, 2'b00, 2'b00, 1'b0);
    check("empty_next_count", 75'(count), 75'(BYP ? 1 : 2));
    check("empty_next_pc", 75'(bus.dec_pc[31:0]), 75'(BYP ? 32'h204 : 32'h200));
    tick();

    // Random traffic with occasional flushes
    pc = 32'h8000;
    for (int n = 0; n < 400; n++) begin
      drive(2'($urandom_range(0, 3)), pc, 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), ($urandom_range(0, 19) == 0));
      tick();
      pc = pc + 32'd8;
    end
    repeat (6) begin
      drive(2'b00, 32'h0, 2'b11, 2'b00, 1'b0);
      tick();
    end
    check("final_count", 75'(count), 75'(0));

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
